// File: rtl/axi_tl_response_merger.sv
// axi_tl_response_merger
//
// Merges the AXI write-response (B) and read-data (R) channels of a
// TileLink-to-AXI bridge into a single TileLink D channel.
//
// Request metadata (opcode, size, source) for outstanding reads and writes
// is queued in two info FIFOs fed by the A-channel splitter. Each A opcode
// is translated into its D opcode on entry, so the FIFO head already holds
// what goes out on d_opcode. Read bursts are forwarded without interruption.
// Reads and writes take turns through a round-robin priority bit.
//
// Ports
//   clk, rstnn                     clock, asynchronous active-low reset
//   rinfo_valid/ready, rinfo_*     read request info push (opcode/size/source)
//   winfo_valid/ready, winfo_*     write request info push (opcode/size/source)
//   bid, bresp, bvalid, bready     AXI B channel
//   rid, rdata, rresp, rlast,
//   rvalid, rready                 AXI R channel
//   d_valid, d_ready, d_*          TileLink D channel
//   rd_pending, wr_pending         info FIFO occupancies
//   protocol_error                 sticky: unexpected rlast position or ID mismatch

// Simple info FIFO: ready = not full, no bypass, head is the oldest entry.
module axi_tl_response_merger_info_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;

    assign push_ready = (count != FULL);
    assign push       = push_valid & push_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module axi_tl_response_merger #(
    parameter int BW_DATA    = 32,
    parameter int BW_SOURCE  = 4,
    parameter int BW_SIZE    = 3,
    parameter int BW_SINK    = 1,
    parameter int BW_AXI_ID  = 4,
    parameter int INFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstnn,

    input  logic                          rinfo_valid,
    output logic                          rinfo_ready,
    input  logic [2:0]                    rinfo_opcode,
    input  logic [BW_SIZE-1:0]            rinfo_size,
    input  logic [BW_SOURCE-1:0]          rinfo_source,

    input  logic                          winfo_valid,
    output logic                          winfo_ready,
    input  logic [2:0]                    winfo_opcode,
    input  logic [BW_SIZE-1:0]            winfo_size,
    input  logic [BW_SOURCE-1:0]          winfo_source,

    input  logic [BW_AXI_ID-1:0]          bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,

    input  logic [BW_AXI_ID-1:0]          rid,
    input  logic [BW_DATA-1:0]            rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,

    input  logic                          d_ready,
    output logic                          d_valid,
    output logic [2:0]                    d_opcode,
    output logic [1:0]                    d_param,
    output logic [BW_SIZE-1:0]            d_size,
    output logic [BW_SOURCE-1:0]          d_source,
    output logic [BW_SINK-1:0]            d_sink,
    output logic                          d_denied,
    output logic [BW_DATA-1:0]            d_data,
    output logic                          d_corrupt,

    output logic [$clog2(INFO_DEPTH):0]   rd_pending,
    output logic [$clog2(INFO_DEPTH):0]   wr_pending,
    output logic                          protocol_error
);
    localparam int LOG_BYTES = $clog2(BW_DATA / 8);
    // Wide enough to hold the beat count of the largest encodable size.
    localparam int CNT_W     = 2 ** BW_SIZE;
    localparam int IW        = 3 + BW_SIZE + BW_SOURCE;

    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] OP_GRANT_DATA      = 3'd5;
    localparam logic [2:0] OP_ACQUIRE_BLOCK   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    typedef enum logic {
        OWN_READ,
        OWN_WRITE
    } owner_e;

    state_e               state;
    owner_e               prio;
    logic                 den_seen;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     exp_last;

    logic [IW-1:0]        rd_head;
    logic [IW-1:0]        wr_head;
    logic [2:0]           rd_op;
    logic [BW_SIZE-1:0]   rd_size;
    logic [BW_SOURCE-1:0] rd_src;
    logic [2:0]           wr_op;
    logic [BW_SIZE-1:0]   wr_size;
    logic [BW_SOURCE-1:0] wr_src;

    logic                 rd_pop;
    logic                 wr_pop;
    logic                 rd_cand;
    logic                 wr_cand;
    logic                 r_fire;
    logic                 b_fire;
    logic                 unused_resp_lsb;

    function automatic logic [2:0] map_rd_opcode(input logic [2:0] a_op);
        return (a_op == OP_ACQUIRE_BLOCK) ? OP_GRANT_DATA : OP_ACCESS_ACK_DATA;
    endfunction

    function automatic logic [2:0] map_wr_opcode(input logic [2:0] a_op);
        // Every write flavour, including unknown ones, is acknowledged plainly.
        return (a_op == 3'd0) ? OP_ACCESS_ACK : OP_ACCESS_ACK;
    endfunction

    axi_tl_response_merger_info_fifo #(
        .W     (IW),
        .DEPTH (INFO_DEPTH)
    ) u_rd_fifo (
        .clk        (clk),
        .rstnn      (rstnn),
        .push_valid (rinfo_valid),
        .push_ready (rinfo_ready),
        .push_data  ({map_rd_opcode(rinfo_opcode), rinfo_size, rinfo_source}),
        .pop        (rd_pop),
        .head       (rd_head),
        .count      (rd_pending)
    );

    axi_tl_response_merger_info_fifo #(
        .W     (IW),
        .DEPTH (INFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rstnn      (rstnn),
        .push_valid (winfo_valid),
        .push_ready (winfo_ready),
        .push_data  ({map_wr_opcode(winfo_opcode), winfo_size, winfo_source}),
        .pop        (wr_pop),
        .head       (wr_head),
        .count      (wr_pending)
    );

    assign {rd_op, rd_size, rd_src} = rd_head;
    assign {wr_op, wr_size, wr_src} = wr_head;

    assign unused_resp_lsb = ^{rresp[0], bresp[0]};

    assign rd_cand = rvalid & (rd_pending != '0);
    assign wr_cand = bvalid & (wr_pending != '0);

    assign r_fire  = (state == ST_READ)  & rvalid & d_ready;
    assign b_fire  = (state == ST_WRITE) & bvalid & d_ready;
    assign rd_pop  = r_fire & rlast;
    assign wr_pop  = b_fire;

    // Index of the beat that should carry rlast: max(1, 2^size/bytes) - 1.
    always_comb begin
        exp_last = '0;
        if (rd_size > BW_SIZE'(LOG_BYTES)) begin
            exp_last = (CNT_W'(1) << (rd_size - BW_SIZE'(LOG_BYTES))) - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state          <= ST_IDLE;
            prio           <= OWN_READ;
            den_seen       <= 1'b0;
            beat_cnt       <= '0;
            protocol_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    den_seen <= 1'b0;
                    if (rd_cand && (!wr_cand || prio == OWN_READ)) begin
                        state <= ST_READ;
                    end else if (wr_cand) begin
                        state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (r_fire) begin
                        if (rid != rd_src[BW_AXI_ID-1:0]) begin
                            protocol_error <= 1'b1;
                        end
                        if (rlast) begin
                            if (beat_cnt != exp_last) begin
                                protocol_error <= 1'b1;
                            end
                            state    <= ST_IDLE;
                            den_seen <= 1'b0;
                            beat_cnt <= '0;
                            prio     <= (prio == OWN_READ) ? OWN_WRITE : OWN_READ;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            // A denied mid-burst beat taints the remainder of the burst.
                            if (rresp[1]) begin
                                den_seen <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (b_fire) begin
                        if (bid != wr_src[BW_AXI_ID-1:0]) begin
                            protocol_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                        prio  <= (prio == OWN_READ) ? OWN_WRITE : OWN_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Channel forwarding is combinational so a burst streams one beat per cycle.
    always_comb begin
        d_valid  = 1'b0;
        rready   = 1'b0;
        bready   = 1'b0;
        d_opcode = '0;
        d_size   = '0;
        d_source = '0;
        d_denied = 1'b0;
        d_data   = '0;
        case (state)
            ST_READ: begin
                d_valid  = rvalid;
                rready   = d_ready;
                d_opcode = rd_op;
                d_size   = rd_size;
                d_source = rd_src;
                d_denied = rresp[1] | den_seen;
                d_data   = rdata;
            end
            ST_WRITE: begin
                d_valid  = bvalid;
                bready   = d_ready;
                d_opcode = wr_op;
                d_size   = wr_size;
                d_source = wr_src;
                d_denied = bresp[1];
            end
            default: begin
            end
        endcase
        d_corrupt = d_denied &
                    ((d_opcode == OP_ACCESS_ACK_DATA) || (d_opcode == OP_GRANT_DATA));
    end

    assign d_param = '0;
    assign d_sink  = '0;
endmodule

// File: tb/tb_axi_tl_response_merger.sv
module tb_axi_tl_response_merger;
    localparam int BW_DATA    = 32;
    localparam int BW_SOURCE  = 4;
    localparam int BW_SIZE    = 3;
    localparam int BW_SINK    = 1;
    localparam int BW_AXI_ID  = 4;
    localparam int INFO_DEPTH = 4;
    localparam int PW         = $clog2(INFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rstnn = 1'b0;
    logic                 rinfo_valid = 1'b0, rinfo_ready;
    logic [2:0]           rinfo_opcode = '0;
    logic [BW_SIZE-1:0]   rinfo_size = '0;
    logic [BW_SOURCE-1:0] rinfo_source = '0;
    logic                 winfo_valid = 1'b0, winfo_ready;
    logic [2:0]           winfo_opcode = '0;
    logic [BW_SIZE-1:0]   winfo_size = '0;
    logic [BW_SOURCE-1:0] winfo_source = '0;
    logic [BW_AXI_ID-1:0] bid = '0;
    logic [1:0]           bresp = '0;
    logic                 bvalid = 1'b0, bready;
    logic [BW_AXI_ID-1:0] rid = '0;
    logic [BW_DATA-1:0]   rdata = '0;
    logic [1:0]           rresp = '0;
    logic                 rlast = 1'b0, rvalid = 1'b0, rready;
    logic                 d_ready = 1'b1, d_valid;
    logic [2:0]           d_opcode;
    logic [1:0]           d_param;
    logic [BW_SIZE-1:0]   d_size;
    logic [BW_SOURCE-1:0] d_source;
    logic [BW_SINK-1:0]   d_sink;
    logic                 d_denied, d_corrupt;
    logic [BW_DATA-1:0]   d_data;
    logic [PW-1:0]        rd_pending, wr_pending;
    logic                 protocol_error;

    axi_tl_response_merger #(
        .BW_DATA    (BW_DATA),
        .BW_SOURCE  (BW_SOURCE),
        .BW_SIZE    (BW_SIZE),
        .BW_SINK    (BW_SINK),
        .BW_AXI_ID  (BW_AXI_ID),
        .INFO_DEPTH (INFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .rinfo_valid    (rinfo_valid),
        .rinfo_ready    (rinfo_ready),
        .rinfo_opcode   (rinfo_opcode),
        .rinfo_size     (rinfo_size),
        .rinfo_source   (rinfo_source),
        .winfo_valid    (winfo_valid),
        .winfo_ready    (winfo_ready),
        .winfo_opcode   (winfo_opcode),
        .winfo_size     (winfo_size),
        .winfo_source   (winfo_source),
        .bid            (bid),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .rid            (rid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
        .d_ready        (d_ready),
        .d_valid        (d_valid),
        .d_opcode       (d_opcode),
        .d_param        (d_param),
        .d_size         (d_size),
        .d_source       (d_source),
        .d_sink         (d_sink),
        .d_denied       (d_denied),
        .d_data         (d_data),
        .d_corrupt      (d_corrupt),
        .rd_pending     (rd_pending),
        .wr_pending     (wr_pending),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]           op;
        logic [BW_SIZE-1:0]   size;
        logic [BW_SOURCE-1:0] src;
        logic                 den;
        logic                 cor;
        logic [BW_DATA-1:0]   data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   dr_toggle = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [2:0] op, input logic [BW_SIZE-1:0] sz,
                           input logic [BW_SOURCE-1:0] src, input logic den,
                           input logic cor, input logic [BW_DATA-1:0] data);
        exp_t e;
        e.op = op; e.size = sz; e.src = src; e.den = den; e.cor = cor; e.data = data;
        sb.push_back(e);
    endtask

    // D-channel monitor: every accepted beat is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rstnn && d_valid && d_ready) begin
            check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("d_opcode",  64'(d_opcode),  64'(e.op));
                check_eq("d_size",    64'(d_size),    64'(e.size));
                check_eq("d_source",  64'(d_source),  64'(e.src));
                check_eq("d_denied",  64'(d_denied),  64'(e.den));
                check_eq("d_corrupt", 64'(d_corrupt), 64'(e.cor));
                check_eq("d_data",    64'(d_data),    64'(e.data));
                check_eq("d_param",   64'(d_param),   64'd0);
                check_eq("d_sink",    64'(d_sink),    64'd0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            d_ready = dr_toggle ? ~d_ready : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic push_rd(input logic [2:0] op, input logic [BW_SIZE-1:0] sz,
                           input logic [BW_SOURCE-1:0] src);
        bit ok = 1'b0;
        rinfo_valid = 1'b1; rinfo_opcode = op; rinfo_size = sz; rinfo_source = src;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = rinfo_ready;
        end
        check_eq("rinfo_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        rinfo_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [2:0] op, input logic [BW_SIZE-1:0] sz,
                           input logic [BW_SOURCE-1:0] src);
        bit ok = 1'b0;
        winfo_valid = 1'b1; winfo_opcode = op; winfo_size = sz; winfo_source = src;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = winfo_ready;
        end
        check_eq("winfo_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        winfo_valid = 1'b0;
    endtask

    task automatic send_r(input logic [BW_AXI_ID-1:0] id, input logic [BW_DATA-1:0] data,
                          input logic [1:0] resp, input logic last);
        bit ok = 1'b0;
        rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = rready;
        end
        check_eq("r_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic send_b(input logic [BW_AXI_ID-1:0] id, input logic [1:0] resp);
        bit ok = 1'b0;
        bvalid = 1'b1; bid = id; bresp = resp;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bready;
        end
        check_eq("b_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_d_valid"},   64'(d_valid),        64'd0);
        check_eq({tag, "_rready"},    64'(rready),         64'd0);
        check_eq({tag, "_bready"},    64'(bready),         64'd0);
        check_eq({tag, "_perr"},      64'(protocol_error), 64'd0);
        check_eq({tag, "_rd_pend"},   64'(rd_pending),     64'd0);
        check_eq({tag, "_wr_pend"},   64'(wr_pending),     64'd0);
        check_eq({tag, "_d_opcode"},  64'(d_opcode),       64'd0);
        check_eq({tag, "_d_source"},  64'(d_source),       64'd0);
        check_eq({tag, "_d_data"},    64'(d_data),         64'd0);
        check_eq({tag, "_rinfo_rdy"}, 64'(rinfo_ready),    64'd1);
        check_eq({tag, "_winfo_rdy"}, 64'(winfo_ready),    64'd1);
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        rinfo_valid = 1'b0; winfo_valid = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        rstnn = 1'b1;
        @(posedge clk); #1;

        // Single Get
        push_rd(3'd4, 3'd2, 4'd3);
        check_eq("t1_rd_pend1", 64'(rd_pending), 64'd1);
        sb_push(3'd1, 3'd2, 4'd3, 1'b0, 1'b0, 32'hA5A5A5A5);
        send_r(4'd3, 32'hA5A5A5A5, 2'b00, 1'b1);
        check_eq("t1_rd_pend0", 64'(rd_pending), 64'd0);

        // PutFullData with SLVERR
        push_wr(3'd0, 3'd2, 4'd5);
        check_eq("t2_wr_pend1", 64'(wr_pending), 64'd1);
        sb_push(3'd0, 3'd2, 4'd5, 1'b1, 1'b0, '0);
        send_b(4'd5, 2'b10);
        check_eq("t2_wr_pend0", 64'(wr_pending), 64'd0);

        // 4-beat burst, DECERR on beat 1, write waiting alongside, d_ready toggling
        push_rd(3'd4, 3'd4, 4'd9);
        push_wr(3'd1, 3'd2, 4'd4);
        for (int i = 0; i < 4; i++) begin
            sb_push(3'd1, 3'd4, 4'd9, (i != 0), (i != 0), 32'h1000_0000 + 32'(i));
        end
        sb_push(3'd0, 3'd2, 4'd4, 1'b0, 1'b0, '0);
        dr_toggle = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_r(4'd9, 32'h1000_0000 + 32'(i), (i == 1) ? 2'b11 : 2'b00, (i == 3));
                end
            end
            send_b(4'd4, 2'b00);
        join
        dr_toggle = 1'b0;
        @(posedge clk); #1;

        // Round-robin: read, write, read, write
        push_rd(3'd6, 3'd2, 4'd1);
        push_rd(3'd2, 3'd2, 4'd2);
        push_wr(3'd0, 3'd2, 4'd7);
        push_wr(3'd3, 3'd2, 4'd8);
        sb_push(3'd5, 3'd2, 4'd1, 1'b0, 1'b0, 32'h0000_1111);
        sb_push(3'd0, 3'd2, 4'd7, 1'b0, 1'b0, '0);
        sb_push(3'd1, 3'd2, 4'd2, 1'b0, 1'b0, 32'h0000_2222);
        sb_push(3'd0, 3'd2, 4'd8, 1'b0, 1'b0, '0);
        fork
            begin
                send_r(4'd1, 32'h0000_1111, 2'b00, 1'b1);
                send_r(4'd2, 32'h0000_2222, 2'b00, 1'b1);
            end
            begin
                send_b(4'd7, 2'b00);
                send_b(4'd8, 2'b00);
            end
        join
        check_eq("t4_sb_drained", 64'(sb.size()), 64'd0);
        check_eq("t4_perr", 64'(protocol_error), 64'd0);

        // FIFO occupancy: simultaneous push/pop, full, refill after pop
        push_rd(3'd4, 3'd2, 4'd1);
        push_rd(3'd4, 3'd2, 4'd2);
        check_eq("t5_pend2", 64'(rd_pending), 64'd2);
        sb_push(3'd1, 3'd2, 4'd1, 1'b0, 1'b0, 32'h0000_0055);
        fork
            send_r(4'd1, 32'h0000_0055, 2'b00, 1'b1);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    seen = d_valid && d_ready;
                end
                check_eq("t5_pop_seen", 64'(seen), 64'd1);
                rinfo_valid = 1'b1; rinfo_opcode = 3'd4; rinfo_size = 3'd2; rinfo_source = 4'd3;
                @(posedge clk); #1;
                rinfo_valid = 1'b0;
            end
        join
        check_eq("t5_pushpop_pend", 64'(rd_pending), 64'd2);
        push_rd(3'd4, 3'd2, 4'd4);
        push_rd(3'd4, 3'd2, 4'd5);
        check_eq("t5_full_pend", 64'(rd_pending), 64'(INFO_DEPTH));
        check_eq("t5_full_ready", 64'(rinfo_ready), 64'd0);
        rinfo_valid = 1'b1; rinfo_opcode = 3'd4; rinfo_size = 3'd2; rinfo_source = 4'd6;
        sb_push(3'd1, 3'd2, 4'd2, 1'b0, 1'b0, 32'h0000_0066);
        send_r(4'd2, 32'h0000_0066, 2'b00, 1'b1);
        rinfo_valid = 1'b1;
        @(posedge clk); #1;
        rinfo_valid = 1'b0;
        check_eq("t5_refill_pend", 64'(rd_pending), 64'(INFO_DEPTH));
        check_eq("t5_refill_ready", 64'(rinfo_ready), 64'd0);
        do_reset();

        // Early rlast on a 4-beat Get
        push_rd(3'd4, 3'd4, 4'd2);
        sb_push(3'd1, 3'd4, 4'd2, 1'b0, 1'b0, 32'hCAFE_0000);
        sb_push(3'd1, 3'd4, 4'd2, 1'b0, 1'b0, 32'hCAFE_0001);
        send_r(4'd2, 32'hCAFE_0000, 2'b00, 1'b0);
        check_eq("t6_perr_mid", 64'(protocol_error), 64'd0);
        send_r(4'd2, 32'hCAFE_0001, 2'b00, 1'b1);
        check_eq("t6_perr_set", 64'(protocol_error), 64'd1);
        check_eq("t6_rd_pend", 64'(rd_pending), 64'd0);
        push_wr(3'd0, 3'd2, 4'd7);
        sb_push(3'd0, 3'd2, 4'd7, 1'b0, 1'b0, '0);
        send_b(4'd7, 2'b00);
        check_eq("t6_perr_sticky", 64'(protocol_error), 64'd1);

        // Reset in the middle of a burst
        push_rd(3'd4, 3'd4, 4'd1);
        sb_push(3'd1, 3'd4, 4'd1, 1'b0, 1'b0, 32'h0000_00A0);
        sb_push(3'd1, 3'd4, 4'd1, 1'b0, 1'b0, 32'h0000_00A1);
        send_r(4'd1, 32'h0000_00A0, 2'b00, 1'b0);
        send_r(4'd1, 32'h0000_00A1, 2'b00, 1'b0);
        do_reset();

        // ID mismatch on a single-beat read
        push_rd(3'd4, 3'd2, 4'd6);
        sb_push(3'd1, 3'd2, 4'd6, 1'b0, 1'b0, 32'h0000_0777);
        send_r(4'd7, 32'h0000_0777, 2'b00, 1'b1);
        check_eq("t7_perr_id", 64'(protocol_error), 64'd1);

        repeat (3) @(posedge clk);
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
